// File: rtl/bd_pkg.sv
// Shared types and parameter limits for the bd_tx 4-phase bundled-data transmitter.
package bd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    REQ_HI,
    RTZ
  } state_t;

  localparam int SETUP_CYC_MIN   = 1;
  localparam int SETUP_CYC_MAX   = 15;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  // Setup counter is sized for the largest legal SETUP_CYC.
  localparam int SETUP_W = $clog2(SETUP_CYC_MAX + 1);

  function automatic int clamp(int v, int lo, int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer with asynchronous clear to 0; also used as the reset-release synchronizer.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= {q[STAGES-2:0], din};
  end

  assign dout = q[STAGES-1];

endmodule

// File: rtl/bd_tx.sv
// Clocked 4-phase bundled-data transmitter: 2-entry FIFO feeding a req/ack handshake FSM.
module bd_tx
  import bd_pkg::*;
#(
  parameter int N           = 32,
  parameter int SETUP_CYC   = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_d,
  output logic         req,
  output logic [N-1:0] d,
  input  logic         ack,
  output logic [1:0]   count,
  output logic         err
);

  localparam int SETUP_EFF = clamp(SETUP_CYC, SETUP_CYC_MIN, SETUP_CYC_MAX);
  localparam int SYNC_EFF  = clamp(SYNC_STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX);
  localparam logic [SETUP_W-1:0] SETUP_LAST = SETUP_W'(SETUP_EFF - 1);

  logic               rst_n;
  logic               ack_s;
  logic [N-1:0]       mem [2];
  logic               wr_ptr;
  logic               rd_ptr;
  logic               ready_en;
  logic               push;
  logic               pop;
  state_t             state;
  logic [SETUP_W-1:0] setup_cnt;

  // Reset asserts immediately but releases synchronously to clk.
  sync_ff #(.STAGES(2)) u_rst_sync (
    .clk   (clk),
    .rst_n (rst),
    .din   (1'b1),
    .dout  (rst_n)
  );

  sync_ff #(.STAGES(SYNC_EFF)) u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (ack),
    .dout  (ack_s)
  );

  assign in_ready = ready_en & (count != 2'd2);
  assign push     = in_valid & in_ready;
  assign pop      = (state == RTZ) & ~ack_s;

  // NOTE: FIFO storage is not reset; an entry is only read while count says it holds a word.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en <= 1'b0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
    end else begin
      ready_en <= 1'b1;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      if (push && !pop)      count <= count + 2'd1;
      else if (!push && pop) count <= count - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req       <= 1'b0;
      d         <= '0;
      err       <= 1'b0;
      setup_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ack_s) begin
            err <= 1'b1;
          end else if (count != 2'd0) begin
            d         <= mem[rd_ptr];
            setup_cnt <= '0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          // A stray ack during setup is flagged and the launch waits for it to clear.
          if (ack_s) begin
            err <= 1'b1;
          end else if (setup_cnt == SETUP_LAST) begin
            req   <= 1'b1;
            state <= REQ_HI;
          end else begin
            setup_cnt <= setup_cnt + 1'b1;
          end
        end
        REQ_HI: begin
          if (ack_s) begin
            req   <= 1'b0;
            state <= RTZ;
          end
        end
        RTZ: begin
          if (!ack_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
